// File: rtl/wb_pkg.sv
// Shared definitions for the vasm writeback stage: opcode values, the
// writeback FSM state type and the instruction class type.
package wb_pkg;

    // Register-write class opcodes
    localparam logic [4:0] OP_ADD   = 5'd2;
    localparam logic [4:0] OP_SUB   = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd5;
    localparam logic [4:0] OP_OR    = 5'd6;
    localparam logic [4:0] OP_XOR   = 5'd7;
    localparam logic [4:0] OP_NOT   = 5'd8;
    localparam logic [4:0] OP_NEG   = 5'd9;
    localparam logic [4:0] OP_SHL   = 5'd10;
    localparam logic [4:0] OP_SHR   = 5'd11;
    localparam logic [4:0] OP_MOV   = 5'd14;
    localparam logic [4:0] OP_LDUMP = 5'd16;
    localparam logic [4:0] OP_SDUMP = 5'd17;

    // Load and halt opcodes
    localparam logic [4:0] OP_LD    = 5'd13;
    localparam logic [4:0] OP_HLT   = 5'd15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LD = 2'd1,
        HALTED  = 2'd2
    } wb_state_t;

    typedef enum logic [1:0] {
        C_NOP = 2'd0,
        C_WR  = 2'd1,
        C_LD  = 2'd2,
        C_HLT = 2'd3
    } wb_class_t;

endpackage

// File: rtl/wb_class_decode.sv
// Combinational opcode classifier: maps a 5-bit opcode to its writeback class.
module wb_class_decode
    import wb_pkg::*;
(
    input  logic [4:0] opcode,
    output wb_class_t  op_class
);

    // Any opcode not listed below retires as a no-op
    always_comb begin
        op_class = C_NOP;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NEG,
            OP_SHL, OP_SHR, OP_MOV, OP_LDUMP, OP_SDUMP: op_class = C_WR;
            OP_LD:                                      op_class = C_LD;
            OP_HLT:                                     op_class = C_HLT;
            default:                                    op_class = C_NOP;
        endcase
    end

endmodule

// File: rtl/wb_stage_hs.sv
// Registered writeback stage between EX and the register file / PC-load path.
// Retires one instruction per accept as a register write pulse, a PC-load
// pulse, a halt, or nothing. Loads wait for memory data under a timeout.
//
// Handshake: an instruction transfers on a rising edge where ex_valid and
// ex_ready are both high. ex_ready depends only on the FSM state (high in
// IDLE), never on ex_valid, so EX may hold ex_valid/ex_ir/ex_z stable until
// the transfer without creating a combinational loop.
module wb_stage_hs
    import wb_pkg::*;
#(
    parameter int DW         = 16,
    parameter int RAW        = 5,
    parameter int IRW        = 32,
    parameter int LD_TIMEOUT = 255,
    parameter int RCW        = 16
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [IRW-1:0]  ex_ir,
    input  logic [DW-1:0]   ex_z,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            reg_write,
    output logic [RAW-1:0]  addr,
    output logic [DW-1:0]   z5,
    output logic            load_pc,
    output logic            hlt,
    output logic            ld_err,
    output logic [RCW-1:0]  retired,
    output logic [1:0]      dbg_state
);

    localparam int TCW = (LD_TIMEOUT < 1) ? 1 : $clog2(LD_TIMEOUT + 1);
    localparam logic [TCW-1:0] T_LAST = TCW'(LD_TIMEOUT - 1);

    wb_state_t       state_q, state_d;
    logic [TCW-1:0]  cnt_q, cnt_d;
    logic [RAW-1:0]  dest_q, dest_d;
    logic            reg_write_q, reg_write_d;
    logic            load_pc_q, load_pc_d;
    logic            hlt_q, hlt_d;
    logic            ld_err_q, ld_err_d;
    logic [RAW-1:0]  addr_q, addr_d;
    logic [DW-1:0]   z5_q, z5_d;
    logic [RCW-1:0]  retired_q, retired_d;

    logic [4:0]      opcode;
    logic [RAW-1:0]  ir_dest;
    wb_class_t       ex_class;
    logic            accept;
    logic            ld_fire;
    logic [RAW-1:0]  ld_dest;
    logic            unused_ir;

    assign opcode    = ex_ir[IRW-1:IRW-5];
    assign ir_dest   = ex_ir[26:27-RAW];
    assign unused_ir = ^ex_ir[26-RAW:0];

    wb_class_decode u_decode (
        .opcode   (opcode),
        .op_class (ex_class)
    );

    assign ex_ready  = (state_q == IDLE);
    assign accept    = ex_valid & ex_ready;

    assign reg_write = reg_write_q;
    assign load_pc   = load_pc_q;
    assign hlt       = hlt_q;
    assign ld_err    = ld_err_q;
    assign addr      = addr_q;
    assign z5        = z5_q;
    assign retired   = retired_q;
    assign dbg_state = state_q;

    // Next-state, timeout counter and retirement outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dest_d      = dest_q;
        reg_write_d = 1'b0;
        load_pc_d   = 1'b0;
        hlt_d       = hlt_q;
        ld_err_d    = ld_err_q;
        addr_d      = addr_q;
        z5_d        = z5_q;
        retired_d   = retired_q;
        ld_fire     = 1'b0;
        ld_dest     = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (ex_class)
                        C_WR: begin
                            reg_write_d = 1'b1;
                            addr_d      = ir_dest;
                            z5_d        = ex_z;
                            retired_d   = retired_q + RCW'(1);
                        end
                        C_LD: begin
                            dest_d = ir_dest;
                            if (mem_rvalid) begin
                                ld_fire = 1'b1;
                                ld_dest = ir_dest;
                            end else begin
                                state_d = WAIT_LD;
                                cnt_d   = '0;
                            end
                        end
                        C_HLT: begin
                            hlt_d     = 1'b1;
                            retired_d = retired_q + RCW'(1);
                            state_d   = HALTED;
                        end
                        default: begin
                            retired_d = retired_q + RCW'(1);
                        end
                    endcase
                end
            end
            WAIT_LD: begin
                // Data arriving on the final allowed cycle still completes
                if (mem_rvalid) begin
                    ld_fire = 1'b1;
                    ld_dest = dest_q;
                    state_d = IDLE;
                end else if (cnt_q == T_LAST) begin
                    ld_err_d = 1'b1;
                    hlt_d    = 1'b1;
                    state_d  = HALTED;
                end else begin
                    cnt_d = cnt_q + TCW'(1);
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A load to r0 redirects the PC instead of writing the register file
        if (ld_fire) begin
            z5_d      = mem_rdata;
            addr_d    = ld_dest;
            retired_d = retired_q + RCW'(1);
            if (ld_dest != '0) begin
                reg_write_d = 1'b1;
            end else begin
                load_pc_d = 1'b1;
            end
        end
    end

    // State and output registers, cleared asynchronously by clr
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dest_q      <= '0;
            reg_write_q <= 1'b0;
            load_pc_q   <= 1'b0;
            hlt_q       <= 1'b0;
            ld_err_q    <= 1'b0;
            addr_q      <= '0;
            z5_q        <= '0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dest_q      <= dest_d;
            reg_write_q <= reg_write_d;
            load_pc_q   <= load_pc_d;
            hlt_q       <= hlt_d;
            ld_err_q    <= ld_err_d;
            addr_q      <= addr_d;
            z5_q        <= z5_d;
            retired_q   <= retired_d;
        end
    end

endmodule
